// File: rtl/gray_arb_pkg.sv
// Shared types and constants for the Gray-code counter arbiter.
// Used by gray_step and gray_arbiter.
package gray_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    // Successor of each 3-bit Gray value, indexed by the current value.
    localparam logic [2:0] GRAY_NEXT [8] = '{3'd1, 3'd3, 3'd6, 3'd2, 3'd0, 3'd4, 3'd7, 3'd5};
    localparam logic [2:0] GRAY_WRAP_FROM = 3'd4;

    function automatic logic [2:0] inc_idx(input logic [2:0] idx, input int n);
        return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/gray_step.sv
// 3-bit Gray step register: advances one code per enabled cycle.
// Wrap flags the step out of GRAY_WRAP_FROM back to zero.
module gray_step
    import gray_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       En,
    input  logic       Clr,
    output logic [2:0] Value,
    output logic       Wrap
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Value <= 3'd0;
        end else if (Clr) begin
            Value <= 3'd0;
        end else if (En) begin
            Value <= GRAY_NEXT[Value];
        end
    end

    assign Wrap = En && !Clr && (Value == GRAY_WRAP_FROM);

endmodule

// File: rtl/gray_arbiter.sv
// Grants one requester at a time a burst of Gray counter steps.
// Define GRAY_ARB_FIXED_PRIO_EN for lowest-index-wins selection; default is round-robin.
module gray_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*CNT_W-1:0] Steps,
    input  logic                  Clr,
    output logic [NREQ-1:0]       Grant,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Abort,
    output logic [2:0]            Done_id,
    output logic [2:0]            Output,
    output logic                  Overflow
);

    // Handshake: Req[i] is a level the client holds until it sees Done or Abort
    // with Done_id == i; Grant[i] marks the current owner; dropping Req while
    // granted aborts the burst on the next edge without stepping the counter.

    arb_state_t       state, state_n;
    logic [2:0]       owner, owner_n, ptr, ptr_n, sel, done_id_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [NREQ-1:0]  grant_n;
    logic             busy_n, done_n, abort_n, overflow_n;
    logic             step_en, wrap, sel_found;
    logic [7:0]       req8;
    logic [CNT_W-1:0] steps8 [8];

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NREQ) begin : g_used
            assign req8[g]   = Req[g];
            assign steps8[g] = Steps[g*CNT_W +: CNT_W];
        end else begin : g_pad
            assign req8[g]   = 1'b0;
            assign steps8[g] = '0;
        end
    end

    always_comb begin
        sel       = 3'd0;
        sel_found = 1'b0;
`ifdef GRAY_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req8[3'(i)]) sel = 3'(i);
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_found && req8[3'((int'(ptr) + i) % NREQ)]) begin
                sel       = 3'((int'(ptr) + i) % NREQ);
                sel_found = 1'b1;
            end
        end
`endif
    end

    assign step_en = (state == RUN) && req8[owner] && !Clr;

    gray_step u_step (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (step_en),
        .Clr   (Clr),
        .Value (Output),
        .Wrap  (wrap)
    );

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rem_n      = rem;
        ptr_n      = ptr;
        grant_n    = Grant;
        busy_n     = Busy;
        done_n     = 1'b0;
        abort_n    = 1'b0;
        done_id_n  = Done_id;
        overflow_n = Overflow;

        if (Clr)       overflow_n = 1'b0;
        else if (wrap) overflow_n = 1'b1;

        case (state)
            IDLE: begin
                if (|Req) begin
                    rem_n   = steps8[sel];
                    owner_n = sel;
                    if (steps8[sel] != '0) begin
                        grant_n = NREQ'(1) << sel;
                        busy_n  = 1'b1;
                        state_n = RUN;
                    end else begin
                        // Zero-length request completes without ever owning the counter.
                        done_n    = 1'b1;
                        done_id_n = sel;
                        ptr_n     = inc_idx(sel, NREQ);
                    end
                end
            end
            RUN: begin
                if (!req8[owner]) begin
                    abort_n   = 1'b1;
                    done_id_n = owner;
                    grant_n   = '0;
                    busy_n    = 1'b0;
                    ptr_n     = inc_idx(owner, NREQ);
                    state_n   = IDLE;
                end else if (!Clr) begin
                    rem_n = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        done_n    = 1'b1;
                        done_id_n = owner;
                        grant_n   = '0;
                        busy_n    = 1'b0;
                        ptr_n     = inc_idx(owner, NREQ);
                        state_n   = IDLE;
                    end
                end
            end
        endcase

`ifdef GRAY_ARB_FIXED_PRIO_EN
        ptr_n = 3'd0;
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            owner    <= 3'd0;
            rem      <= '0;
            ptr      <= 3'd0;
            Grant    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Abort    <= 1'b0;
            Done_id  <= 3'd0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rem      <= rem_n;
            ptr      <= ptr_n;
            Grant    <= grant_n;
            Busy     <= busy_n;
            Done     <= done_n;
            Abort    <= abort_n;
            Done_id  <= done_id_n;
            Overflow <= overflow_n;
        end
    end

endmodule

// File: tb/tb_gray_arbiter.sv
// Directed self-checking bench for gray_arbiter; expected values are hand-derived.
// Build with +define+GRAY_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_gray_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;

    logic                  Clk = 1'b0;
    logic                  Reset = 1'b0;
    logic [NREQ-1:0]       Req = '0;
    logic [NREQ*CNT_W-1:0] Steps = '0;
    logic                  Clr = 1'b0;
    logic [NREQ-1:0]       Grant;
    logic                  Busy, Done, Abort, Overflow;
    logic [2:0]            Done_id, Output;

    bit clk_run = 1'b1;
    int total = 0;
    int bad = 0;
    logic [NREQ-1:0] exp_q[$];
    logic [2:0] wrap_seq [9] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1};
    logic [2:0] t1_out [4]   = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [3:0] t1_grant [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    logic       t1_done [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       seen;

    gray_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Steps    (Steps),
        .Clr      (Clr),
        .Grant    (Grant),
        .Busy     (Busy),
        .Done     (Done),
        .Abort    (Abort),
        .Done_id  (Done_id),
        .Output   (Output),
        .Overflow (Overflow)
    );

    // clock / reset
    always begin
        #5;
        if (clk_run) Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clr_pulse();
        Clr = 1'b1;
        cycle();
        Clr = 1'b0;
    endtask

    task automatic set_steps(input int i, input logic [CNT_W-1:0] v);
        Steps[i*CNT_W +: CNT_W] = v;
    endtask

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
        end
    endtask

    initial begin
        #12;
        @(negedge Clk);
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_abort", 32'(Abort), 32'd0);
        check("rst_done_id", 32'(Done_id), 32'd0);
        check("rst_output", 32'(Output), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        Reset = 1'b1;
        cycle();

        // arbitration order with every requester asking for one step
`ifdef GRAY_ARB_FIXED_PRIO_EN
        repeat (5) exp_q.push_back(4'b0001);
`else
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
`endif
        for (int i = 0; i < NREQ; i++) set_steps(i, 4'd1);
        Req = 4'b1111;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            cycle();
            if (Grant != '0) check("arb_grant", 32'(Grant), 32'(exp_q.pop_front()));
        end
        if (exp_q.size() != 0) check("arb_timeout", 32'(exp_q.size()), 32'd0);
        cycle();
        check("arb_done", 32'(Done), 32'd1);
        check("arb_done_id", 32'(Done_id), 32'd0);
        Req = '0;
        check("arb_output", 32'(Output), 32'd7);
        clr_pulse();
        check("idle_clr_output", 32'(Output), 32'd0);

        // simple three-step burst
        set_steps(0, 4'd3);
        Req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("b3_output", 32'(Output), 32'(t1_out[k]));
            check("b3_grant", 32'(Grant), 32'(t1_grant[k]));
            check("b3_done", 32'(Done), 32'(t1_done[k]));
        end
        check("b3_done_id", 32'(Done_id), 32'd0);
        Req = '0;
        cycle();
        check("b3_done_pulse", 32'(Done), 32'd0);

        // nine steps through the wrap, then clear
        clr_pulse();
        set_steps(2, 4'd9);
        Req = 4'b0100;
        cycle();
        check("wrap_grant", 32'(Grant), 32'b0100);
        for (int k = 0; k < 9; k++) begin
            cycle();
            check("wrap_output", 32'(Output), 32'(wrap_seq[k]));
            check("wrap_overflow", 32'(Overflow), (k >= 7) ? 32'd1 : 32'd0);
        end
        check("wrap_done", 32'(Done), 32'd1);
        check("wrap_done_id", 32'(Done_id), 32'd2);
        Req = '0;
        clr_pulse();
        check("wrap_clr_output", 32'(Output), 32'd0);
        check("wrap_clr_overflow", 32'(Overflow), 32'd0);

        // owner drops Req after two of five steps
        set_steps(3, 4'd5);
        Req = 4'b1000;
        cycle();
        check("abort_grant", 32'(Grant), 32'b1000);
        cycle();
        cycle();
        check("abort_pre_output", 32'(Output), 32'd3);
        Req = '0;
        cycle();
        check("abort_pulse", 32'(Abort), 32'd1);
        check("abort_done_id", 32'(Done_id), 32'd3);
        check("abort_no_done", 32'(Done), 32'd0);
        check("abort_grant_off", 32'(Grant), 32'd0);
        check("abort_output", 32'(Output), 32'd3);
        seen = 1'b0;
        repeat (3) begin
            cycle();
            seen = seen | Done | (Output != 3'd3);
        end
        check("abort_quiet", 32'(seen), 32'd0);

        // zero-length request
        set_steps(1, 4'd0);
        Req = 4'b0010;
        cycle();
        check("zero_grant", 32'(Grant), 32'd0);
        check("zero_done", 32'(Done), 32'd1);
        check("zero_done_id", 32'(Done_id), 32'd1);
        check("zero_output", 32'(Output), 32'd3);
        Req = '0;
        cycle();
        check("zero_done_pulse", 32'(Done), 32'd0);

        // asynchronous reset mid-burst with the clock stopped
        clr_pulse();
        set_steps(0, 4'd12);
        Req = 4'b0001;
        cycle();
        repeat (10) cycle();
        check("mid_output", 32'(Output), 32'd3);
        check("mid_overflow", 32'(Overflow), 32'd1);
        check("mid_busy", 32'(Busy), 32'd1);
        clk_run = 1'b0;
        #2 Reset = 1'b0;
        #1;
        check("async_grant", 32'(Grant), 32'd0);
        check("async_output", 32'(Output), 32'd0);
        check("async_overflow", 32'(Overflow), 32'd0);
        check("async_busy", 32'(Busy), 32'd0);
        Req = '0;
        #2 Reset = 1'b1;
        clk_run = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            cycle();
            seen = seen | Done | Abort;
        end
        check("async_no_pulse", 32'(seen), 32'd0);

        // Clr during a burst delays completion by one cycle
        set_steps(0, 4'd3);
        Req = 4'b0001;
        cycle();
        check("rclr_grant", 32'(Grant), 32'b0001);
        cycle();
        check("rclr_step1", 32'(Output), 32'd1);
        Clr = 1'b1;
        cycle();
        Clr = 1'b0;
        check("rclr_output", 32'(Output), 32'd0);
        check("rclr_hold_grant", 32'(Grant), 32'b0001);
        check("rclr_no_done", 32'(Done), 32'd0);
        cycle();
        check("rclr_step2", 32'(Output), 32'd1);
        check("rclr_still_grant", 32'(Grant), 32'b0001);
        cycle();
        check("rclr_step3", 32'(Output), 32'd3);
        check("rclr_done", 32'(Done), 32'd1);
        check("rclr_grant_off", 32'(Grant), 32'd0);
        Req = '0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
